// File: rtl/trivium_ctrl.sv
// trivium_ctrl: Trivium sequencer (key/IV capture, load, 1152-cycle warm-up, keystream handshake).
// Ports: clk_i/n_rst_i, start_i/stop_i, key_i/iv_i, ld_o/ce_o/ld_{a,b,c}_o, z_i, ks_o/ks_valid_o/ks_ready_i, busy_o.
module trivium_ctrl #(
    parameter int INIT_CYCLES = 1152,
    parameter int CNT_W       = 11
) (
    input  logic         clk_i,
    input  logic         n_rst_i,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic [79:0]  key_i,
    input  logic [79:0]  iv_i,
    output logic         ld_o,
    output logic         ce_o,
    output logic [92:0]  ld_a_o,
    output logic [83:0]  ld_b_o,
    output logic [110:0] ld_c_o,
    input  logic         z_i,
    output logic         ks_o,
    output logic         ks_valid_o,
    input  logic         ks_ready_i,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WARM,
        GEN
    } state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(INIT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [79:0]      key_q, key_d;
    logic [79:0]      iv_q, iv_d;
    logic             ld_q, ld_d;
    logic             warm_q, warm_d;
    logic             gen_q, gen_d;
    logic             busy_q, busy_d;
    logic             gen_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        iv_d    = iv_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    key_d   = key_i;
                    iv_d    = iv_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = stop_i ? IDLE : WARM;
            end
            WARM: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (stop_i) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = GEN;
                end
            end
            GEN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    key_d   = key_i;
                    iv_d    = iv_i;
                    state_d = LOAD;
                end
            end
        endcase
        // Output flags are registered from the next state.
        ld_d   = (state_d == LOAD);
        warm_d = (state_d == WARM);
        gen_d  = (state_d == GEN);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            iv_q    <= '0;
            ld_q    <= 1'b0;
            warm_q  <= 1'b0;
            gen_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            iv_q    <= iv_d;
            ld_q    <= ld_d;
            warm_q  <= warm_d;
            gen_q   <= gen_d;
            busy_q  <= busy_d;
        end
    end

    // A re-key or abort cycle in GEN offers no bit, so nothing is consumed.
    assign gen_ok     = gen_q & ~start_i & ~stop_i;
    assign ks_valid_o = gen_ok;
    assign ks_o       = z_i;
    assign ce_o       = warm_q | (gen_ok & ks_ready_i);
    assign ld_o       = ld_q;
    assign busy_o     = busy_q;

    assign ld_a_o = {13'b0, key_q};
    assign ld_b_o = {4'b0, iv_q};
    assign ld_c_o = {3'b111, 108'b0};

endmodule

// File: tb/tb_trivium_ctrl.sv
// tb_trivium_ctrl: directed bench for trivium_ctrl with a Trivium slice datapath
// and an independent bit-serial software reference of the cipher.
module tb_trivium_ctrl;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic         stop;
    logic [79:0]  key;
    logic [79:0]  iv;
    logic         ld;
    logic         ce;
    logic [92:0]  ld_a;
    logic [83:0]  ld_b;
    logic [110:0] ld_c;
    logic         z;
    logic         ks;
    logic         ks_valid;
    logic         ks_ready;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic ref_bits [0:511];

    localparam logic [79:0]  K1   = 80'h0123456789ABCDEF0123;
    localparam logic [79:0]  IVF  = {80{1'b1}};
    localparam logic [79:0]  K2   = 80'h13579BDF02468ACE1122;
    localparam logic [79:0]  IV2  = 80'hA5A5_0000_FFFF_1234_5678;
    localparam logic [79:0]  K3   = 80'hDEADBEEFCAFEF00D7777;
    localparam logic [79:0]  IV3  = 80'h0000_0000_0000_0000_0001;
    localparam logic [79:0]  K4   = 80'h8000_0000_0000_0000_0001;
    localparam logic [79:0]  IV4  = 80'h1111_2222_3333_4444_5555;
    localparam logic [110:0] LDC  = {3'b111, 108'b0};

    always #5 clk = ~clk;

    trivium_ctrl dut (
        .clk_i      (clk),
        .n_rst_i    (n_rst),
        .start_i    (start),
        .stop_i     (stop),
        .key_i      (key),
        .iv_i       (iv),
        .ld_o       (ld),
        .ce_o       (ce),
        .ld_a_o     (ld_a),
        .ld_b_o     (ld_b),
        .ld_c_o     (ld_c),
        .z_i        (z),
        .ks_o       (ks),
        .ks_valid_o (ks_valid),
        .ks_ready_i (ks_ready),
        .busy_o     (busy)
    );

    // Datapath: slice A = s1..s93, B = s94..s177, C = s178..s288.
    logic [92:0]  sa;
    logic [83:0]  sb;
    logic [110:0] sc;
    logic         t1, t2, t3;

    assign t1 = sa[65] ^ sa[92] ^ (sa[90] & sa[91]) ^ sb[77];
    assign t2 = sb[68] ^ sb[83] ^ (sb[81] & sb[82]) ^ sc[86];
    assign t3 = sc[65] ^ sc[110] ^ (sc[108] & sc[109]) ^ sa[68];
    assign z  = sa[65] ^ sa[92] ^ sb[68] ^ sb[83] ^ sc[65] ^ sc[110];

    always @(posedge clk) begin
        if (ld) begin
            sa <= ld_a;
            sb <= ld_b;
            sc <= ld_c;
        end else if (ce) begin
            sa <= {sa[91:0], t3};
            sb <= {sb[82:0], t1};
            sc <= {sc[109:0], t2};
        end
    end

    task automatic gen_ref(input logic [79:0] k, input logic [79:0] v,
                           input int n);
        logic [1:288] s;
        logic ta, tb, tc;
        s = '0;
        for (int i = 0; i < 80; i++) begin
            s[i+1]  = k[i];
            s[94+i] = v[i];
        end
        s[286] = 1'b1;
        s[287] = 1'b1;
        s[288] = 1'b1;
        for (int r = 0; r < 1152 + n; r++) begin
            ta = s[66] ^ s[93];
            tb = s[162] ^ s[177];
            tc = s[243] ^ s[288];
            if (r >= 1152) ref_bits[r-1152] = ta ^ tb ^ tc;
            ta = ta ^ (s[91] & s[92]) ^ s[171];
            tb = tb ^ (s[175] & s[176]) ^ s[264];
            tc = tc ^ (s[286] & s[287]) ^ s[69];
            s = {tc, s[1:92], ta, s[94:176], tb, s[178:287]};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gen(output int nce);
        int k;
        nce = 0;
        for (k = 0; k < 1400; k++) begin
            #1;
            if (ks_valid) break;
            if (ce) nce++;
            tick();
        end
        n_checks++;
        if (k == 1400) begin
            n_fail++;
            $display("FAIL wait_gen: no ks_valid after %0d cycles, required within 1400", k);
        end
    endtask

    task automatic consume(input int n, inout int idx);
        for (int j = 0; j < n; j++) begin
            ks_ready = 1'b1;
            #1;
            n_checks++;
            if (ks_valid !== 1'b1 || ce !== 1'b1 || ks !== ref_bits[idx]) begin
                n_fail++;
                $display("FAIL ks_bit[%0d]: valid=%b ce=%b ks=%b, required 1 1 %b",
                         idx, ks_valid, ce, ks, ref_bits[idx]);
            end
            idx++;
            tick();
        end
        ks_ready = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            start    = 1'($urandom);
            stop     = 1'($urandom);
            ks_ready = 1'($urandom);
            key      = {$urandom, $urandom, 16'($urandom)};
            iv       = {$urandom, $urandom, 16'($urandom)};
            #1;
            n_checks++;
            if ({ld, ce, ks_valid, busy} !== 4'b0 || ld_a !== '0 ||
                ld_b !== '0 || ld_c !== LDC) begin
                n_fail++;
                $display("FAIL reset: ld=%b ce=%b v=%b busy=%b a=%0h b=%0h c=%0h",
                         ld, ce, ks_valid, busy, ld_a, ld_b, ld_c);
            end
        end
        start    = 1'b0;
        stop     = 1'b0;
        ks_ready = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_load_warm();
        int n;
        int idx;
        int ldn;
        gen_ref(K1, IVF, 8);
        key   = K1;
        iv    = IVF;
        start = 1'b1;
        #1;
        n_checks++;
        if (ld !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_start: ld=%b busy=%b, required 0 0", ld, busy);
        end
        tick();
        start = 1'b0;
        key   = '0;
        iv    = '0;
        #1;
        n_checks++;
        if (ld !== 1'b1 || ce !== 1'b0 || busy !== 1'b1 ||
            ld_a !== {13'b0, K1} || ld_b !== {4'b0, IVF} || ld_c !== LDC) begin
            n_fail++;
            $display("FAIL load: ld=%b ce=%b busy=%b a=%0h b=%0h, required 1 0 1 %0h %0h",
                     ld, ce, busy, ld_a, ld_b, {13'b0, K1}, {4'b0, IVF});
        end
        tick();
        n   = 0;
        ldn = 0;
        for (int k = 0; k < 1300; k++) begin
            #1;
            if (!ce) break;
            if (ld || ks_valid) ldn++;
            n++;
            tick();
        end
        n_checks++;
        if (n != 1152 || ldn != 0) begin
            n_fail++;
            $display("FAIL warm_count: ce cycles=%0d stray=%0d, required 1152 0", n, ldn);
        end
        n_checks++;
        if (ks_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL gen_entry: valid=%b busy=%b, required 1 1", ks_valid, busy);
        end
        idx = 0;
        consume(8, idx);
    endtask

    task automatic test_kat_backpressure();
        int nce;
        int idx;
        logic held;
        go_idle();
        gen_ref('0, '0, 320);
        key   = '0;
        iv    = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_gen(nce);
        n_checks++;
        if (nce != 1152) begin
            n_fail++;
            $display("FAIL kat_warm: ce cycles=%0d, required 1152", nce);
        end
        idx = 0;
        consume(256, idx);
        consume(10, idx);
        ks_ready = 1'b0;
        #1;
        held = ks;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (ce !== 1'b0 || ks_valid !== 1'b1 || ks !== held) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: ce=%b v=%b ks=%b, required 0 1 %b",
                         i, ce, ks_valid, ks, held);
            end
            tick();
        end
        consume(20, idx);
    endtask

    task automatic test_abort_ignore();
        int n;
        int idx;
        go_idle();
        gen_ref(K2, IV2, 16);
        key   = K2;
        iv    = IV2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n = 0;
        for (int k = 0; k < 1300; k++) begin
            #1;
            if (!ce) break;
            n++;
            if (n == 501) begin
                start = 1'b1;
                key   = K3;
                iv    = IV3;
            end
            tick();
            start = 1'b0;
        end
        n_checks++;
        if (n != 1152 || ks_valid !== 1'b1 || ld_a !== {13'b0, K2}) begin
            n_fail++;
            $display("FAIL start_in_warm: ce cycles=%0d v=%b a=%0h, required 1152 1 %0h",
                     n, ks_valid, ld_a, {13'b0, K2});
        end
        idx = 0;
        consume(16, idx);

        go_idle();
        key   = K2;
        iv    = IV2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n = 0;
        for (int k = 0; k < 1300; k++) begin
            #1;
            if (!ce || n == 700) break;
            n++;
            tick();
        end
        stop  = 1'b1;
        start = 1'b1;
        key   = K3;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        #1;
        n_checks++;
        if (n != 700 || busy !== 1'b0 || ce !== 1'b0 || ld !== 1'b0 ||
            ks_valid !== 1'b0 || ld_a !== {13'b0, K2}) begin
            n_fail++;
            $display("FAIL stop_in_warm: n=%0d busy=%b ce=%b ld=%b v=%b a=%0h, required 700 0 0 0 0 %0h",
                     n, busy, ce, ld, ks_valid, ld_a, {13'b0, K2});
        end
        tick();
        #1;
        n_checks++;
        if (busy !== 1'b0 || ld !== 1'b0) begin
            n_fail++;
            $display("FAIL stay_idle: busy=%b ld=%b, required 0 0", busy, ld);
        end
    endtask

    task automatic test_rekey();
        int nce;
        int idx;
        gen_ref(K3, IV3, 4);
        key   = K3;
        iv    = IV3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_gen(nce);
        idx = 0;
        consume(4, idx);
        ks_ready = 1'b1;
        start    = 1'b1;
        key      = K4;
        iv       = IV4;
        #1;
        n_checks++;
        if (ce !== 1'b0 || ks_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rekey_cycle: ce=%b v=%b, required 0 0", ce, ks_valid);
        end
        tick();
        start    = 1'b0;
        ks_ready = 1'b0;
        #1;
        n_checks++;
        if (ld !== 1'b1 || ce !== 1'b0 || ld_a !== {13'b0, K4} ||
            ld_b !== {4'b0, IV4}) begin
            n_fail++;
            $display("FAIL rekey_load: ld=%b ce=%b a=%0h b=%0h, required 1 0 %0h %0h",
                     ld, ce, ld_a, ld_b, {13'b0, K4}, {4'b0, IV4});
        end
        tick();
        wait_gen(nce);
        n_checks++;
        if (nce != 1152) begin
            n_fail++;
            $display("FAIL rekey_warm: ce cycles=%0d, required 1152", nce);
        end
        gen_ref(K4, IV4, 32);
        idx = 0;
        consume(32, idx);
    endtask

    task automatic test_async_reset();
        ks_ready = 1'b1;
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if ({ld, ce, ks_valid, busy} !== 4'b0 || ld_a !== '0 ||
            ld_b !== '0 || ld_c !== LDC) begin
            n_fail++;
            $display("FAIL async_reset: ld=%b ce=%b v=%b busy=%b a=%0h b=%0h",
                     ld, ce, ks_valid, busy, ld_a, ld_b);
        end
        @(negedge clk);
        n_rst    = 1'b1;
        ks_ready = 1'b0;
        tick();
        #1;
        n_checks++;
        if (busy !== 1'b0 || ks_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: busy=%b v=%b, required 0 0", busy, ks_valid);
        end
    endtask

    initial begin
        n_rst    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        ks_ready = 1'b0;
        key      = '0;
        iv       = '0;
        test_reset();
        test_load_warm();
        test_kat_backpressure();
        test_abort_ignore();
        test_rekey();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
